// File: rtl/uart_tx_stim.sv
// Bench-side UART transmitter: bytes from a valid/ready FIFO are sent 8N1, LSB first, back-to-back.
// Define UART_TX_STIM_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_stim #(
    parameter int unsigned CLOCK_FREQUENCY = 25_000_000,
    parameter int unsigned UART_BAUD_RATE  = 57600,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic                        uart_tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        tx_done_o
);
    localparam int unsigned CYCLES_PER_BAUD = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(CYCLES_PER_BAUD);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CYCLES_PER_BAUD - 1);

`ifdef UART_TX_STIM_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_baud_last;
    logic [7:0]    w_rd_data;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_done;
`ifdef UART_TX_STIM_PARITY_EN
    logic          r_parity;
`endif

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == PW'(FIFO_DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_push      = valid_i && !w_full;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_rd_data   = r_mem[r_rd_ptr[AW-1:0]];

    assign ready_o      = !w_full;
    assign busy_o       = (r_state != S_IDLE) || !w_empty;
    assign fifo_count_o = w_count;
    assign uart_tx_o    = r_tx;
    assign tx_done_o    = r_done;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
        end
    end

    // Frame sequencer; the line and done pulse lag the state by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_rd_ptr  <= '0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
`ifdef UART_TX_STIM_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_rd_data;
`ifdef UART_TX_STIM_PARITY_EN
                        r_parity  <= ^w_rd_data;
`endif
                        r_rd_ptr  <= r_rd_ptr + PW'(1);
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_STIM_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
`ifdef UART_TX_STIM_PARITY_EN
                S_PARITY: begin
                    r_tx <= r_parity;
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_last) begin
                        r_done  <= 1'b1;
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed bench for uart_tx_stim at 10 clocks per bit with a 4-entry FIFO.
module tb_uart_tx_stim;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DEPTH  = 4;
    localparam int CPB = 10;
`ifdef UART_TX_STIM_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB + 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] count;
    logic          done;

    uart_tx_stim #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .UART_BAUD_RATE (BAUD),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data),
        .valid_i     (valid),
        .ready_o     (ready),
        .uart_tx_o   (tx),
        .busy_o      (busy),
        .fifo_count_o(count),
        .tx_done_o   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Occupancy and ready consistency watched every cycle.
    int max_cnt = 0;
    int rdy_bad = 0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (ready !== (count != CW'(DEPTH))) rdy_bad++;
        end
    end

    // Receiver model: samples mid-bit, drops frames cut by reset.
    logic [7:0] rx_data [$];
    int         rx_time [$];
    logic       rx_ok   [$];
    logic       rx_par  [$];
    initial begin : rx_model
        logic [10:0] fr;
        int          t;
        logic        ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                t  = cyc;
                ab = 1'b0;
                fr = '1;
                for (int c = 1; c < NBITS * CPB; c++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) ab = 1'b1;
                    if (c % CPB == CPB / 2) fr[c / CPB] = tx;
                end
                if (!ab) begin
                    rx_data.push_back(fr[8:1]);
                    rx_time.push_back(t);
                    rx_ok.push_back(!fr[0] && fr[NBITS-1]);
                    rx_par.push_back(fr[9]);
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output int acc);
        int guard = 0;
        data  = b;
        valid = 1'b1;
        while (!ready && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc   = cyc;
        valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic line_s [128];
    logic done_s [128];
    logic busy_s [128];

    function automatic logic [9:0] seg(input int lo);
        logic [9:0] s;
        for (int i = 0; i < 10; i++) s[i] = line_s[lo + i];
        return s;
    endfunction

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int         t0;
        int         acc;
        int         base;
        int         nd;
        logic [7:0] b;
        logic [7:0] exp_b [6];

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        wait_cycles(3);
        check("rst_tx",    32'(tx),    32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        rst = 1'b0;
        wait_cycles(2);

        // Single byte 0xA5, cycle-exact waveform
        base = rx_data.size();
        b = 8'hA5;
        push(b, t0);
        check("t1_count0", 32'(count), 32'd1);
        check("t1_busy0",  32'(busy),  32'd1);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            line_s[k] = tx;
            done_s[k] = done;
            busy_s[k] = busy;
        end
        check("t1_idle_c1", 32'(line_s[1]), 32'd1);
        check("t1_start",   32'(seg(2)),    32'h000);
        for (int i = 0; i < 8; i++)
            check($sformatf("t1_d%0d", i), 32'(seg(12 + 10 * i)), b[i] ? 32'h3FF : 32'h000);
`ifdef UART_TX_STIM_PARITY_EN
        check("t1_parity", 32'(seg(92)), (^b) ? 32'h3FF : 32'h000);
`endif
        check("t1_stop",      32'(seg(2 + CPB * (NBITS - 1))), 32'h3FF);
        check("t1_after",     32'(seg(FRAME + 1)),             32'h3FF);
        check("t1_done_at",   32'(done_s[FRAME]),              32'd1);
        nd = 0;
        for (int k = 0; k < 128; k++) if (done_s[k]) nd++;
        check("t1_done_cnt",  nd,                        1);
        check("t1_busy_last", 32'(busy_s[FRAME - 1]),    32'd1);
        check("t1_busy_end",  32'(busy_s[FRAME]),        32'd0);
        check("t1_rx_n",      rx_data.size() - base,     1);
        if (rx_data.size() > base) begin
            check("t1_rx_byte", 32'(rx_data[base]), 32'hA5);
            check("t1_rx_time", rx_time[base] - t0, 2);
            check("t1_rx_ok",   32'(rx_ok[base]),   32'd1);
        end

        // Burst of three bytes
        base = rx_data.size();
        exp_b[0] = 8'h55; exp_b[1] = 8'h0F; exp_b[2] = 8'hF0;
        push(exp_b[0], t0);
        push(exp_b[1], acc);
        push(exp_b[2], acc);
        wait_cycles(3 * FRAME + 20);
        check("t2_rx_n", rx_data.size() - base, 3);
        if (rx_data.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t2_byte%0d", i), 32'(rx_data[base + i]), 32'(exp_b[i]));
                check($sformatf("t2_time%0d", i), rx_time[base + i] - t0, 2 + i * FRAME);
                check($sformatf("t2_ok%0d", i),   32'(rx_ok[base + i]),   32'd1);
            end
        end
        check("t2_busy",  32'(busy),  32'd0);
        check("t2_count", 32'(count), 32'd0);

        // Fill the FIFO; the sixth byte must wait for the second pop
        base = rx_data.size();
        for (int i = 0; i < 6; i++) exp_b[i] = 8'(8'h11 * (i + 1));
        push(exp_b[0], t0);
        for (int i = 1; i < 5; i++) push(exp_b[i], acc);
        check("t3_acc5",   acc - t0,     4);
        check("t3_ready0", 32'(ready),   32'd0);
        check("t3_full",   32'(count),   32'd4);
        push(exp_b[5], acc);
        check("t3_acc6",   acc - t0,     FRAME + 2);
        wait_cycles(5 * FRAME + 20);
        check("t3_rx_n", rx_data.size() - base, 6);
        if (rx_data.size() >= base + 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("t3_byte%0d", i), 32'(rx_data[base + i]), 32'(exp_b[i]));
        end
        check("t3_max_cnt", max_cnt, 4);
        check("t3_rdy_bad", rdy_bad, 0);

        // Reset during data bit 3 of 0x3C with a second byte queued
        base = rx_data.size();
        push(8'h3C, t0);
        push(8'h00, acc);
        wait_cycles(44);
        check("t4_bit3",    32'(tx),    32'd1);
        check("t4_count",   32'(count), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_tx",    32'(tx),    32'd1);
        check("t4_rst_count", 32'(count), 32'd0);
        check("t4_rst_busy",  32'(busy),  32'd0);
        check("t4_rst_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(3 * FRAME);
        check("t4_no_frame", rx_data.size() - base, 0);
        check("t4_idle_tx",  32'(tx),   32'd1);
        check("t4_idle_bsy", 32'(busy), 32'd0);

        // Reset during the start bit releases the line at once
        push(8'h00, t0);
        wait_cycles(5);
        check("t4b_start_low", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t4b_rst_tx",   32'(tx),   32'd1);
        check("t4b_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(2 * FRAME);
        check("t4b_no_frame", rx_data.size() - base, 0);

        // Loopback of the extreme patterns
        base = rx_data.size();
        push(8'h00, t0);
        push(8'hFF, acc);
        wait_cycles(2 * FRAME + 20);
        check("t5_rx_n", rx_data.size() - base, 2);
        if (rx_data.size() >= base + 2) begin
            check("t5_byte00", 32'(rx_data[base]),     32'h00);
            check("t5_byteFF", 32'(rx_data[base + 1]), 32'hFF);
            check("t5_ok0",    32'(rx_ok[base]),       32'd1);
            check("t5_ok1",    32'(rx_ok[base + 1]),   32'd1);
        end

`ifdef UART_TX_STIM_PARITY_EN
        // Even parity on 0x07 and 0x03
        base = rx_data.size();
        push(8'h07, t0);
        push(8'h03, acc);
        wait_cycles(2 * FRAME + 20);
        check("t6_rx_n", rx_data.size() - base, 2);
        if (rx_data.size() >= base + 2) begin
            check("t6_par07", 32'(rx_par[base]),     32'd1);
            check("t6_par03", 32'(rx_par[base + 1]), 32'd0);
            check("t6_period", rx_time[base + 1] - rx_time[base], 111);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_stim.md
Name: uart_tx_stim

Overview:
- Testbench-side UART transmitter that drives serial characters into the core's UART RX pin (the inbound direction of the stdout/stdin link).
- Bench code pushes bytes through a valid/ready interface into an internal FIFO.
- Framing: 8N1 (1 start, 8 data LSB-first, 1 stop), no flow control. Bytes are sent back-to-back while the FIFO is non-empty.
- Sits next to the UART print peripheral in tb_axi. Output connects to the subsystem rx_i.

Parameters:
- CLOCK_FREQUENCY, 25_000_000, frequency of clk_i in Hz.
- UART_BAUD_RATE, 57600, line baud rate. CYCLES_PER_BAUD = CLOCK_FREQUENCY / UART_BAUD_RATE (integer divide), must be >= 4.
- FIFO_DEPTH, 8, number of byte entries. Power of two, >= 2.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept; equals !full.
- uart_tx_o  output  1  serial line, idle high.
- busy_o  output  1  high while a frame is in progress or the FIFO is non-empty.
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_done_o  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (async, rst_i=1) clears the FIFO and sets the FSM to IDLE. Output reset values: uart_tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0, tx_done_o=0.
- Reset mid-frame aborts the frame: the line goes high immediately and the partial byte is discarded.
- Push: a byte is written on a rising edge with valid_i && ready_o. With valid_i while full, nothing is written and data_i must be held (standard valid/ready rule).
- ready_o is combinational from occupancy only. It does not depend on a same-cycle pop, so there is no push-through-when-full.
- Pop happens only in IDLE when occupancy > 0 before the edge. A byte pushed on edge N into an empty FIFO is popped on edge N+1; there is no bypass.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH, with an extra MSB to distinguish full from empty.
- FSM states:
  - IDLE: line=1. If not empty: pop into shift register, baud counter=0, go to START.
  - START: line=0 for CYCLES_PER_BAUD cycles, then DATA with bit index 0.
  - DATA: line=shift[0], held CYCLES_PER_BAUD cycles, then shift right and increment the index. After index 7 completes, go to STOP (or PARITY, see below).
  - STOP: line=1 for CYCLES_PER_BAUD cycles. tx_done_o pulses in the last cycle of STOP. Then go to IDLE.
- uart_tx_o is registered. The start bit appears on edge N+1 after the pop decision in IDLE.
- Back-to-back frames: one IDLE cycle between a STOP and the next START, so the frame period is 10*CYCLES_PER_BAUD+1 cycles.
- Baud counter counts 0..CYCLES_PER_BAUD-1. It resets to 0 on each state/bit transition.
- busy_o = (state != IDLE) || (occupancy != 0).

Optional Feature:
- Macro UART_TX_STIM_PARITY_EN.
- When defined: an even-parity bit (XOR of the 8 data bits) is inserted in a PARITY state between DATA and STOP, held CYCLES_PER_BAUD cycles. The frame period becomes 11*CYCLES_PER_BAUD+1.
- When undefined: there is no PARITY state and the frame is 8N1 exactly.

Test Plan (CLOCK_FREQUENCY=1_000_000, UART_BAUD_RATE=100_000 → 10 cycles/bit, FIFO_DEPTH=4):
- Single byte: push 0xA5 at edge 0, idle FIFO.
  - Line low over cycles 2..11, then data bits 1,0,1,0,0,1,0,1 each 10 cycles.
  - Stop high; tx_done_o pulse at cycle 101; busy_o=0 afterwards.
- Burst: push 0x55,0x0F,0xF0 back-to-back.
  - Three frames, each 101 cycles apart; a decoding receiver gets the same bytes in order.
- Full: push 5 bytes with valid_i held.
  - ready_o=0 after the 4th accept while the first frame is running (first pop already freed one slot, so the 5th is accepted on that pop edge); fifo_count_o never exceeds 4.
  - No byte is lost or duplicated.
- Reset mid-frame: assert rst_i during data bit 3 of 0x3C.
  - uart_tx_o=1 in the same cycle; fifo_count_o=0; after release no frame is emitted without a new push.
- Loopback to the UART receiver model with CYCLES_PER_BAUD matched, sending 0x00 and 0xFF → both are received correctly.
- With UART_TX_STIM_PARITY_EN: send 0x07 → parity bit 1; send 0x03 → parity bit 0; frame period 111 cycles.
